// File: rtl/fetch_sequencer_pkg.sv
// Shared definitions for the instruction-fetch sequencer: default widths,
// the halt opcode and the fetch FSM state encoding.
package fetch_sequencer_pkg;

  localparam int         ADDR_W_DEF      = 5;
  localparam int         INSTR_W_DEF     = 16;
  localparam logic [3:0] HALT_OP_DEF     = 4'hF;
  localparam int         TIMEOUT_CYC_DEF = 15;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_FETCH = 3'd1;
  localparam state_t ST_DRAIN = 3'd2;
  localparam state_t ST_HOLD  = 3'd3;
  localparam state_t ST_HALT  = 3'd4;

  // States in which the sequencer is waiting on an instruction-memory response.
  function automatic logic is_wait(input state_t s);
    return (s == ST_FETCH) || (s == ST_DRAIN);
  endfunction

endpackage

// File: rtl/fetch_sequencer_timeout_ctr.sv
// Watchdog counter for memory responses; used by fetch_sequencer only when
// FETCH_TIMEOUT_EN is defined.
module fetch_timeout_ctr #(
  parameter  int TIMEOUT_CYC = 15,
  localparam int CW          = $clog2(TIMEOUT_CYC + 1)
) (
  input  logic clk,
  input  logic res_n,
  input  logic clear_i,
  input  logic inc_i,
  output logic expire_o
);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i)    cnt_d = '0;
    else if (inc_i) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!res_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  // Fires on the idle cycle that would bring the count to TIMEOUT_CYC.
  assign expire_o = inc_i && (cnt_q == CW'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction-fetch control stage: drives the PC register, fetches from imem
// into ir and hands it to decode. Optional watchdog: FETCH_TIMEOUT_EN.
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter int         ADDR_W      = ADDR_W_DEF,
  parameter int         INSTR_W     = INSTR_W_DEF,
  parameter logic [3:0] HALT_OP     = HALT_OP_DEF,
  parameter int         TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic               clk,
  input  logic               res_n,
  input  logic               start,
  input  logic [ADDR_W-1:0]  pc_value,
  output logic [ADDR_W-1:0]  pc_in,
  output logic               pc_load,
  output logic               pc_inc,
  output logic               pc_clr,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_valid,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] ir,
  output logic [ADDR_W-1:0]  ir_pc,
  output logic               ir_valid,
  input  logic               ir_ready,
  input  logic               br_taken,
  input  logic [ADDR_W-1:0]  br_target,
  output logic               halted,
  output logic               fetch_err,
  output logic [2:0]         dbg_state
);

  // Decode handshake: the word in ir transfers on a cycle with ir_valid=1,
  // ir_ready=1 and br_taken=0; ir_valid only falls without a transfer when a
  // redirect discards the held instruction.

  state_t             state_q, state_d;
  logic [INSTR_W-1:0] ir_q, ir_d;
  logic [ADDR_W-1:0]  ir_pc_q, ir_pc_d;
  logic               ir_valid_q, ir_valid_d;
  logic               fetch_err_q, fetch_err_d;
  logic               br_act;
  logic               tmo_expire;

  assign br_act = br_taken && (state_q != ST_HALT);

`ifdef FETCH_TIMEOUT_EN
  fetch_timeout_ctr #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_tmo (
    .clk      (clk),
    .res_n    (res_n),
    .clear_i  (is_wait(state_d) && (state_d != state_q)),
    .inc_i    (is_wait(state_q) && !imem_valid),
    .expire_o (tmo_expire)
  );
`else
  assign tmo_expire = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    ir_d        = ir_q;
    ir_pc_d     = ir_pc_q;
    ir_valid_d  = ir_valid_q;
    fetch_err_d = fetch_err_q;
    if (br_act) begin
      // A response still outstanding must be drained before refetching.
      ir_valid_d = 1'b0;
      state_d    = (is_wait(state_q) && !imem_valid) ? ST_DRAIN : ST_FETCH;
    end else if (tmo_expire) begin
      fetch_err_d = 1'b1;
      state_d     = ST_HALT;
    end else begin
      case (state_q)
        ST_IDLE:  if (start) state_d = ST_FETCH;
        ST_FETCH: if (imem_valid) begin
          ir_d       = imem_rdata;
          ir_pc_d    = pc_value;
          ir_valid_d = 1'b1;
          state_d    = ST_HOLD;
        end
        ST_DRAIN: if (imem_valid) state_d = ST_FETCH;
        ST_HOLD:  if (ir_ready) begin
          ir_valid_d = 1'b0;
          state_d    = (ir_q[INSTR_W-1 -: 4] == HALT_OP) ? ST_HALT : ST_FETCH;
        end
        ST_HALT:  state_d = ST_HALT;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!res_n) begin
      state_q     <= ST_IDLE;
      ir_q        <= '0;
      ir_pc_q     <= '0;
      ir_valid_q  <= 1'b0;
      fetch_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ir_q        <= ir_d;
      ir_pc_q     <= ir_pc_d;
      ir_valid_q  <= ir_valid_d;
      fetch_err_q <= fetch_err_d;
    end
  end

  assign pc_in     = br_target;
  assign pc_load   = br_act;
  assign pc_inc    = (state_q == ST_FETCH) && imem_valid && !br_taken;
  assign pc_clr    = ~res_n;
  assign imem_req  = (state_q == ST_FETCH);
  assign imem_addr = pc_value;
  assign ir        = ir_q;
  assign ir_pc     = ir_pc_q;
  assign ir_valid  = ir_valid_q;
  assign halted    = (state_q == ST_HALT);
  assign fetch_err = fetch_err_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: models the PC register and a variable-latency
// memory, and checks delivered instructions against program order.
module tb_fetch_sequencer;

  localparam int AW = 5;
  localparam int IW = 16;

  logic          clk = 1'b0;
  logic          res_n, start, pc_load, pc_inc, pc_clr, imem_req;
  logic          imem_valid, ir_valid, ir_ready, br_taken, halted, fetch_err;
  logic [AW-1:0] pc_value, pc_in, imem_addr, ir_pc, br_target;
  logic [IW-1:0] imem_rdata, ir;
  logic [2:0]    dbg_state;

  always #5 clk = ~clk;

  fetch_sequencer dut (
    .clk(clk), .res_n(res_n), .start(start), .pc_value(pc_value),
    .pc_in(pc_in), .pc_load(pc_load), .pc_inc(pc_inc), .pc_clr(pc_clr),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_valid(imem_valid),
    .imem_rdata(imem_rdata), .ir(ir), .ir_pc(ir_pc), .ir_valid(ir_valid),
    .ir_ready(ir_ready), .br_taken(br_taken), .br_target(br_target),
    .halted(halted), .fetch_err(fetch_err), .dbg_state(dbg_state)
  );

  logic [IW-1:0] mem [32];
  int            n_checks = 0;
  int            n_pass   = 0;
  int            n_fail   = 0;

  // Environment: PC register and memory with a latency range in cycles.
  logic [AW-1:0] pc_next  = '0;
  logic [AW-1:0] req_addr = '0;
  bit            pend     = 0;
  int            rem      = 0;
  int            lat_min  = 1;
  int            lat_max  = 1;
  bit            gen_en   = 1;

  // Reference: address of the next instruction in program order.
  logic [AW-1:0] exp_pc     = '0;
  bit            exp_halted = 0;
  int            delivered  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic rand_mem();
    for (int i = 0; i < 32; i++) mem[i] = {4'($urandom_range(14, 0)), 12'($urandom)};
    mem[$urandom_range(31, 0)][15:12] = 4'hF;
  endtask

  // One clock: drive after the edge, check and update the model at negedge.
  task automatic cycle(input logic rn, input logic st, input logic rdy,
                       input logic br, input logic [AW-1:0] tgt);
    logic [IW-1:0] w;
    @(posedge clk); #1;
    pc_value   = pc_next;
    res_n      = rn;
    start      = st;
    ir_ready   = rdy;
    br_taken   = br;
    br_target  = tgt;
    imem_valid = 1'b0;
    imem_rdata = IW'($urandom);
    if (!rn) pend = 0;
    else if (pend) begin
      rem--;
      if (rem == 0) begin
        imem_valid = 1'b1;
        imem_rdata = mem[req_addr];
        pend       = 0;
      end
    end else if (imem_req) begin
      pend     = 1;
      rem      = $urandom_range(lat_max, lat_min);
      req_addr = pc_value;
    end
    @(negedge clk);
    if (!rn) begin
      chk("pc_clr_in_reset", pc_clr, 1);
      exp_pc     = '0;
      exp_halted = 0;
    end else if (gen_en) begin
      chk("halted", halted, exp_halted);
      chk("fetch_err", fetch_err, 0);
      chk("load_inc_excl", pc_load & pc_inc, 0);
      chk("pc_load", pc_load, br && !exp_halted);
      chk("pc_in", pc_in, tgt);
      if (exp_halted) chk("halt_quiet", {imem_req, pc_inc}, 0);
      if (imem_req) chk("imem_addr", imem_addr, exp_pc);
      w = mem[exp_pc];
      if (ir_valid) begin
        chk("ir", ir, w);
        chk("ir_pc", ir_pc, exp_pc);
      end
      if (br && !exp_halted) exp_pc = tgt;
      else if (ir_valid && rdy) begin
        delivered++;
        if (w[15:12] == 4'hF) exp_halted = 1;
        exp_pc = exp_pc + 1'b1;
      end
    end
    if (pc_clr)       pc_next = '0;
    else if (pc_load) pc_next = pc_in;
    else if (pc_inc)  pc_next = pc_value + 1'b1;
    else              pc_next = pc_value;
  endtask

  initial begin
    int halt_cnt;
    res_n = 0; start = 0; ir_ready = 0; br_taken = 0; br_target = '0;
    imem_valid = 0; imem_rdata = '0; pc_value = '0;
    rand_mem();
    for (int i = 0; i < 32; i++) if (mem[i][15:12] == 4'hF) mem[i] = 16'h0100;
    mem[0] = 16'h1234; mem[7] = 16'h0707; mem[20] = 16'h2014; mem[31] = 16'hF000;

    // Reset values.
    cycle(0, 0, 0, 0, '0);
    cycle(0, 0, 0, 0, '0);
    cycle(1, 0, 0, 0, '0);
    chk("rst_state", dbg_state, 0);
    chk("rst_ir", ir, 0);
    chk("rst_ir_pc", ir_pc, 0);
    chk("rst_ir_valid", ir_valid, 0);
    chk("rst_halted", halted, 0);
    chk("rst_fetch_err", fetch_err, 0);
    chk("rst_imem_req", imem_req, 0);

    // Basic fetch with 1-cycle memory.
    cycle(1, 1, 0, 0, '0);
    cycle(1, 0, 0, 0, '0);
    chk("fetch_req", imem_req, 1);
    chk("fetch_no_inc_yet", pc_inc, 0);
    cycle(1, 0, 0, 0, '0);
    chk("fetch_pc_inc", pc_inc, 1);
    cycle(1, 0, 0, 0, '0);
    chk("basic_ir", ir, 16'h1234);
    chk("basic_ir_pc", ir_pc, 0);
    chk("basic_ir_valid", ir_valid, 1);

    // Back-pressure.
    for (int i = 0; i < 5; i++) begin
      cycle(1, 0, 0, 0, '0);
      chk("bp_ir", ir, 16'h1234);
      chk("bp_valid", ir_valid, 1);
      chk("bp_no_inc", pc_inc, 0);
      chk("bp_no_req", imem_req, 0);
    end

    // Redirect in HOLD discards ir even with ir_ready=1.
    cycle(1, 0, 1, 1, 5'd20);
    chk("redir_load", pc_load, 1);
    chk("redir_no_inc", pc_inc, 0);
    lat_min = 3; lat_max = 3;
    cycle(1, 0, 0, 0, '0);
    chk("redir_ir_valid", ir_valid, 0);
    chk("redir_req", imem_req, 1);
    chk("redir_addr", imem_addr, 20);

    // Redirect with request outstanding: drain the stale response.
    cycle(1, 0, 0, 1, 5'd7);
    cycle(1, 0, 0, 0, '0);
    chk("drain_state", dbg_state, 2);
    chk("drain_no_req", imem_req, 0);
    cycle(1, 0, 0, 0, '0);
    chk("drain_stale_valid", imem_valid, 1);
    lat_min = 1; lat_max = 1;
    cycle(1, 0, 0, 0, '0);
    chk("drain_dropped", ir_valid, 0);
    chk("drain_refetch", imem_addr, 7);
    cycle(1, 0, 0, 0, '0);
    cycle(1, 0, 0, 0, '0);
    chk("target_ir", ir, 16'h0707);
    chk("target_ir_pc", ir_pc, 7);

    // Halt word at PC 31: PC wraps, ir_pc keeps 31.
    cycle(1, 0, 0, 1, 5'd31);
    cycle(1, 0, 0, 0, '0);
    cycle(1, 0, 0, 0, '0);
    chk("wrap_pc_inc", pc_inc, 1);
    cycle(1, 0, 1, 0, '0);
    chk("wrap_ir", ir, 16'hF000);
    chk("wrap_ir_pc", ir_pc, 31);
    chk("wrap_not_halted_yet", halted, 0);
    cycle(1, 1, 1, 1, 5'd3);
    chk("halt_flag", halted, 1);
    chk("halt_ignores_br", pc_load, 0);
    for (int i = 0; i < 3; i++) cycle(1, 1, 1, 1, AW'($urandom));
    chk("halt_pc_wrapped", pc_value, 0);

    // Randomized traffic with occasional mid-flight resets.
    halt_cnt = 0;
    lat_min = 1; lat_max = 3;
    cycle(0, 0, 0, 0, '0);
    rand_mem();
    for (int n = 0; n < 1500; n++) begin
      halt_cnt = exp_halted ? halt_cnt + 1 : 0;
      if (halt_cnt > 3 || $urandom_range(0, 199) == 0) begin
        cycle(0, 0, 0, 0, '0);
        rand_mem();
        halt_cnt = 0;
      end else begin
        cycle(1, 1'($urandom_range(0, 1)), $urandom_range(0, 99) < 70,
              $urandom_range(0, 99) < 8, AW'($urandom_range(31, 0)));
      end
    end
    chk("delivered_enough", delivered > 40, 1);

`ifdef FETCH_TIMEOUT_EN
    // Silent memory: watchdog halts exactly 15 cycles after entering FETCH.
    lat_min = 1000; lat_max = 1000; gen_en = 0;
    cycle(0, 0, 0, 0, '0);
    cycle(1, 1, 0, 0, '0);
    for (int k = 1; k <= 16; k++) begin
      cycle(1, 0, 0, 0, '0);
      chk("tmo_halted", halted, k == 16);
      chk("tmo_err", fetch_err, k == 16);
    end
    cycle(0, 0, 0, 0, '0);
    cycle(1, 0, 0, 0, '0);
    chk("tmo_rst_err", fetch_err, 0);
    chk("tmo_rst_halted", halted, 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Instruction-fetch control stage that sits directly downstream of the 5-bit program counter register and drives it.
- Reads the current PC, issues a request to instruction memory and captures the returned word into an instruction register.
- Presents that word to decode with a valid/ready handshake.
- Generates the PC register's load/inc/clear controls, including branch redirects and halt.

Parameters:
- ADDR_W, 5, PC / instruction-memory address width.
- INSTR_W, 16, instruction width.
- HALT_OP, 4'hF, opcode (instr[INSTR_W-1:INSTR_W-4]) that halts fetch.
- TIMEOUT_CYC, 15, max cycles waiting on imem_valid (optional feature only).

Ports:
- clk  in  1  clock, rising edge.
- res_n  in  1  synchronous active-low reset.
- start  in  1  leave IDLE and begin fetching.
- pc_value  in  ADDR_W  current PC register output.
- pc_in  out  ADDR_W  load value for PC register.
- pc_load  out  1  PC load strobe.
- pc_inc  out  1  PC increment strobe.
- pc_clr  out  1  PC clear; equals ~res_n, combinational.
- imem_req  out  1  fetch request.
- imem_addr  out  ADDR_W  fetch address.
- imem_valid  in  1  response valid.
- imem_rdata  in  INSTR_W  response data.
- ir  out  INSTR_W  instruction register.
- ir_pc  out  ADDR_W  PC of the instruction in ir.
- ir_valid  out  1  ir holds an unconsumed instruction.
- ir_ready  in  1  decode accepts ir.
- br_taken  in  1  redirect request.
- br_target  in  ADDR_W  redirect address.
- halted  out  1  fetch stopped on HALT_OP.
- fetch_err  out  1  timeout flag (optional feature only; tied 0 otherwise).

Behaviour:
- Reset: all registers reset on a clk edge with res_n=0. State=IDLE; ir=0, ir_pc=0, ir_valid=0, halted=0, fetch_err=0. pc_clr=1 while res_n=0.
- States: IDLE, FETCH, DRAIN, HOLD, HALT.
- pc_load, pc_inc and imem_req are combinational from state and inputs. pc_load and pc_inc are never both 1.
- pc_in = br_target at all times.
- IDLE:
  - start=1 -> FETCH.
  - No outputs asserted except via br_taken.
- FETCH:
  - imem_req=1, imem_addr=pc_value.
  - imem_valid=1 and br_taken=0: same cycle pc_inc=1. Next edge: ir<=imem_rdata, ir_pc<=pc_value, ir_valid<=1, state -> HOLD.
  - Memory latency is variable, at least 1 cycle.
  - The response address is the PC at the time of the response. The PC is stable throughout FETCH.
- HOLD:
  - ir, ir_pc and ir_valid are held until ir_ready=1.
  - On ir_ready=1: ir_valid<=0. If ir opcode==HALT_OP -> HALT, else -> FETCH.
  - One bubble cycle per instruction; minimum 3 cycles per instruction with 1-cycle memory.
- HALT:
  - halted=1, imem_req=0, no PC strobes.
  - br_taken is ignored. Exit only by reset.
- br_taken=1, in any state except HALT:
  - pc_load=1 and pc_inc=0 the same cycle.
  - ir_valid<=0; the instruction in ir is discarded even if ir_ready=1.
  - Next state is DRAIN if state is FETCH and imem_valid=0 (request outstanding); otherwise FETCH.
  - If imem_valid=1 in that same cycle, the response is dropped.
- DRAIN:
  - imem_req=0.
  - Wait for imem_valid, drop the response, then -> FETCH.
  - br_taken during DRAIN: load the PC again, remain in DRAIN.
- Priority: res_n=0 > br_taken > imem_valid / ir_ready.
- PC wrap (31->0) is done by the PC register; ir_pc records 31 unchanged.
- Reset mid-fetch: any later imem_valid is ignored because state is IDLE.

Optional Feature:
- Macro FETCH_TIMEOUT_EN.
- Defined:
  - A $clog2(TIMEOUT_CYC+1)-bit counter clears on entry to FETCH/DRAIN and increments each cycle imem_valid=0.
  - Reaching TIMEOUT_CYC: fetch_err<=1 (sticky until reset), state -> HALT, halted=1.
- Undefined: no counter; fetch_err tied 0; waiting is unbounded.

Decomposition:
- Shared package holds:
  - State encoding typedef: IDLE=0, FETCH=1, DRAIN=2, HOLD=3, HALT=4.
  - ADDR_W and INSTR_W defaults.
  - HALT_OP constant.
- One sub-module: fetch_timeout_ctr, the watchdog counter, instantiated only under FETCH_TIMEOUT_EN.

Test Plan:
- Basic fetch: reset, start, 1-cycle memory returning 16'h1234 at PC 0 -> pc_inc pulses once; ir=16'h1234, ir_pc=0, ir_valid=1 next cycle; held until ir_ready.
- Back-pressure: ir_ready=0 for 5 cycles -> ir stable, no pc_inc, imem_req=0 throughout.
- Redirect in HOLD: br_taken with target 5'd20 -> pc_load=1 same cycle, ir_valid=0 next cycle, next imem_addr=20.
- Redirect while request outstanding: 3-cycle memory, br_taken on cycle 1 -> DRAIN; stale response dropped; ir never shows it; fetch resumes at target.
- Halt and wrap: word 16'hF000 at PC 31 -> ir_pc=31, pc_inc pulses (PC becomes 0); after ir_ready, halted=1; later br_taken and start have no effect.
- Timeout (FETCH_TIMEOUT_EN): imem_valid held 0 -> fetch_err=1 and halted=1 exactly TIMEOUT_CYC cycles after entering FETCH; reset clears both.
